// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache placed
// between the EXE/MEM pipeline register and the SRAM controller.
module cache_controller #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdEnIn,
  input  logic        wrEnIn,
  input  logic [31:0] addressIn,
  input  logic [31:0] writeDataIn,
  output logic [31:0] readDataOut,
  output logic        readyOut,
  output logic        sramRdEnOut,
  output logic        sramWrEnOut,
  output logic [31:0] sramAddressOut,
  output logic [31:0] sramWriteDataOut,
  input  logic [63:0] sramReadDataIn,
  input  logic        sramReadyIn
);

  localparam int SETS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SETS-1:0]     valid0_q, valid1_q;
  logic [SETS-1:0]     lru_q;
  logic [TAG_BITS-1:0] tag0_q  [SETS];
  logic [TAG_BITS-1:0] tag1_q  [SETS];
  logic [63:0]         data0_q [SETS];
  logic [63:0]         data1_q [SETS];

  logic                  word_sel_s;
  logic [INDEX_BITS-1:0] index_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic                  hit0_s, hit1_s, hit_s;
  logic [63:0]           hit_line_s;
  logic                  victim_s;
  logic                  fill_en_s;
  logic                  wupd_en_s;
  logic                  lru_we_s;
  logic                  lru_val_s;

  function automatic logic [31:0] pick_word(input logic [63:0] line, input logic sel);
    if (sel) begin
      return line[63:32];
    end else begin
      return line[31:0];
    end
  endfunction

  // Address split and combinational hit detection for the current request.
  always_comb begin
    word_sel_s = addressIn[2];
    index_s    = addressIn[3 +: INDEX_BITS];
    tag_s      = addressIn[3 + INDEX_BITS +: TAG_BITS];
    hit0_s     = valid0_q[index_s] && (tag0_q[index_s] == tag_s);
    hit1_s     = valid1_q[index_s] && (tag1_q[index_s] == tag_s);
    hit_s      = hit0_s || hit1_s;
    hit_line_s = hit0_s ? data0_q[index_s] : data1_q[index_s];
    // Invalid way0 first, then invalid way1, else the LRU victim (lru=1 -> way1).
    victim_s   = valid0_q[index_s] && (!valid1_q[index_s] || lru_q[index_s]);
  end

  // Next-state, pipeline/SRAM outputs and array update strobes.
  always_comb begin
    state_d          = state_q;
    readyOut         = 1'b0;
    readDataOut      = 32'h0000_0000;
    sramRdEnOut      = 1'b0;
    sramWrEnOut      = 1'b0;
    sramAddressOut   = 32'h0000_0000;
    sramWriteDataOut = 32'h0000_0000;
    fill_en_s        = 1'b0;
    wupd_en_s        = 1'b0;
    lru_we_s         = 1'b0;
    lru_val_s        = 1'b0;
    case (state_q)
      IDLE: begin
        if (wrEnIn) begin
          state_d = WRITE;
        end else if (rdEnIn) begin
          if (hit_s) begin
            readyOut    = 1'b1;
            readDataOut = pick_word(hit_line_s, word_sel_s);
            lru_we_s    = 1'b1;
            lru_val_s   = hit0_s;
          end else begin
            state_d = READ_MISS;
          end
        end else begin
          readyOut = 1'b1;
        end
      end
      READ_MISS: begin
        sramRdEnOut    = 1'b1;
        sramAddressOut = {addressIn[31:3], 3'b000};
        if (sramReadyIn) begin
          fill_en_s   = 1'b1;
          lru_we_s    = 1'b1;
          lru_val_s   = !victim_s;
          readyOut    = 1'b1;
          readDataOut = pick_word(sramReadDataIn, word_sel_s);
          state_d     = IDLE;
        end else begin
          state_d = READ_MISS;
        end
      end
      WRITE: begin
        sramWrEnOut      = 1'b1;
        sramAddressOut   = addressIn;
        sramWriteDataOut = writeDataIn;
        if (sramReadyIn) begin
          readyOut = 1'b1;
          state_d  = IDLE;
          if (hit_s) begin
            wupd_en_s = 1'b1;
            lru_we_s  = 1'b1;
            lru_val_s = hit0_s;
          end else begin
            wupd_en_s = 1'b0;
          end
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, valid and LRU bits; reset aborts any in-flight SRAM transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en_s) begin
        if (victim_s) begin
          valid1_q[index_s] <= 1'b1;
        end else begin
          valid0_q[index_s] <= 1'b1;
        end
      end
      if (lru_we_s) begin
        lru_q[index_s] <= lru_val_s;
      end
    end
  end

  // Tag and data arrays need no reset; valid bits qualify their contents.
  always_ff @(posedge clk) begin
    if (!rst && fill_en_s) begin
      if (victim_s) begin
        tag1_q[index_s]  <= tag_s;
        data1_q[index_s] <= sramReadDataIn;
      end else begin
        tag0_q[index_s]  <= tag_s;
        data0_q[index_s] <= sramReadDataIn;
      end
    end else if (!rst && wupd_en_s) begin
      if (hit0_s) begin
        if (word_sel_s) begin
          data0_q[index_s][63:32] <= writeDataIn;
        end else begin
          data0_q[index_s][31:0] <= writeDataIn;
        end
      end else begin
        if (word_sel_s) begin
          data1_q[index_s][63:32] <= writeDataIn;
        end else begin
          data1_q[index_s][31:0] <= writeDataIn;
        end
      end
    end
  end

endmodule
